convo_accumulator: RTL

- Consumer end of the convolver sample-pair stream; the sample selector produces (x index, h index) pairs for output index n, and this block accumulates the Booth products for those pairs into y[n].
- Counts the expected terms for n internally, sums the signed products, and presents y[n] on a valid/ready output port.
- Sits between the Booth multiplier output and the result memory/writer.

---
 rtl/convo_accumulator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/convo_accumulator.sv
// Accumulates signed Booth products for one convolution output y[n] and
// presents the sum on a valid/ready port; expected term count is derived from n.
module convo_accumulator #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 20,
  parameter int IDX_W   = 4,
  parameter int SEQ_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  fr_lconvo,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  y_out,
  output logic [IDX_W-1:0]  y_idx,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy,
  output logic              term_err,
  output logic              all_done
);

  // state | meaning
  // IDLE  | waiting for start
  // ACCUM | summing products until exp_terms have arrived
  // EMIT  | y_out/y_idx held valid until accepted
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam int LAST_IDX = 2 * SEQ_LEN - 2;
  localparam int CNT_W    = $clog2(SEQ_LEN + 1);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, y_out_q, y_out_d;
  logic [ACC_W-1:0]  prod_ext, sum;
  logic [CNT_W-1:0]  term_cnt_q, term_cnt_d, exp_terms_q, exp_terms_d;
  logic [CNT_W-1:0]  cnt_next, start_terms;
  logic [IDX_W-1:0]  n_q, n_d, y_idx_q, y_idx_d;
  logic              y_valid_q, y_valid_d, busy_q, busy_d;
  logic              term_err_q, term_err_d, all_done_q, all_done_d;

  function automatic logic [CNT_W-1:0] terms_for(input logic [IDX_W-1:0] n);
    int ni;
    ni = int'(n);
    if (ni <= SEQ_LEN - 1)     return CNT_W'(ni + 1);
    else if (ni <= LAST_IDX)   return CNT_W'(2 * SEQ_LEN - 1 - ni);
    else                       return '0;
  endfunction

  assign prod_ext    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum         = acc_q + prod_ext;
  assign cnt_next    = term_cnt_q + 1'b1;
  assign start_terms = terms_for(fr_lconvo);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    term_cnt_d  = term_cnt_q;
    exp_terms_d = exp_terms_q;
    n_d         = n_q;
    y_out_d     = y_out_q;
    y_idx_d     = y_idx_q;
    y_valid_d   = y_valid_q;
    all_done_d  = all_done_q;
    term_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (prod_valid) term_err_d = 1'b1;
        if (start) begin
          n_d         = fr_lconvo;
          acc_d       = '0;
          term_cnt_d  = '0;
          exp_terms_d = start_terms;
          if (fr_lconvo == '0) all_done_d = 1'b0;
          if (start_terms == '0) begin
            // Out-of-range index: emit a zero result so the writer still sees y[n].
            y_out_d    = '0;
            y_idx_d    = fr_lconvo;
            y_valid_d  = 1'b1;
            term_err_d = 1'b1;
            state_d    = EMIT;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (start) term_err_d = 1'b1;
        if (prod_valid) begin
          acc_d      = sum;
          term_cnt_d = cnt_next;
          if (cnt_next == exp_terms_q) begin
            y_out_d   = sum;
            y_idx_d   = n_q;
            y_valid_d = 1'b1;
            state_d   = EMIT;
          end
        end
      end
      EMIT: begin
        if (start || prod_valid) term_err_d = 1'b1;
        if (y_ready) begin
          y_valid_d = 1'b0;
          state_d   = IDLE;
          if (y_idx_q == IDX_W'(LAST_IDX)) all_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      term_cnt_q  <= '0;
      exp_terms_q <= '0;
      n_q         <= '0;
      y_out_q     <= '0;
      y_idx_q     <= '0;
      y_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      term_err_q  <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      term_cnt_q  <= term_cnt_d;
      exp_terms_q <= exp_terms_d;
      n_q         <= n_d;
      y_out_q     <= y_out_d;
      y_idx_q     <= y_idx_d;
      y_valid_q   <= y_valid_d;
      busy_q      <= busy_d;
      term_err_q  <= term_err_d;
      all_done_q  <= all_done_d;
    end
  end

  assign y_out    = y_out_q;
  assign y_idx    = y_idx_q;
  assign y_valid  = y_valid_q;
  assign busy     = busy_q;
  assign term_err = term_err_q;
  assign all_done = all_done_q;

endmodule
